// File: rtl/accumulator_pkg.sv
// Shared types and helpers for the systolic-array result buffer.
// Provides the beat mode enum, the default lane width and the count-width helper.
package accumulator_pkg;

    typedef enum logic {
        ACC_OVERWRITE  = 1'b0,
        ACC_ACCUMULATE = 1'b1
    } acc_mode_t;

    localparam int ACC_DATA_W = 32;

    // Width needed to hold 0..depth inclusive.
    function automatic int acc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/accumulator_lane.sv
// One channel of the result buffer: DEPTH x DATA_W store, adder, registered read mux.
// Ports: clk/reset, wr_en_i/wr_row_i/mode_i/wr_data_i (write), clear_i,
//        rd_en_i/rd_row_i (read request), rd_data_o (registered read data).
module accumulator_lane
    import accumulator_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int DEPTH  = 2,
    parameter int RW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [RW-1:0]     wr_row_i,
    input  acc_mode_t         mode_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              clear_i,
    input  logic              rd_en_i,
    input  logic [RW-1:0]     rd_row_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam logic [RW:0] DEPTH_V = (RW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] wr_val_d;
    logic [DATA_W-1:0] rd_val_d;
    logic              rd_in_range;

    // Sum keeps only DATA_W bits: accumulation wraps.
    always_comb begin
        wr_val_d = wr_data_i;
        if (mode_i == ACC_ACCUMULATE) begin
            wr_val_d = mem_q[wr_row_i] + wr_data_i;
        end
    end

    // Rows past DEPTH (non-power-of-2 depth) read back as zero.
    assign rd_in_range = ({1'b0, rd_row_i} < DEPTH_V);

    always_comb begin
        rd_val_d = '0;
        if (rd_in_range) begin
            rd_val_d = mem_q[rd_row_i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_row_i] <= wr_val_d;
        end
    end

    // Read samples the pre-edge store, so same-edge writes/clears are not visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_val_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/accumulator_bank.sv
// Result buffer under the systolic array: stores one CHANNELS-wide row per valid beat.
// Ports: clk, reset, in_valid/in_data/mode (beat), rewind, clear, rd_en/rd_row (read),
//        rd_data/rd_valid (registered read), count, full, drop_err (status).
module accumulator_bank
    import accumulator_pkg::*;
#(
    parameter int DATA_W   = ACC_DATA_W,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 2,
    parameter int RW       = $clog2(DEPTH),
    parameter int CW       = acc_cnt_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic                       mode,
    input  logic                       rewind,
    input  logic                       clear,
    input  logic                       rd_en,
    input  logic [RW-1:0]              rd_row,
    output logic [CHANNELS*DATA_W-1:0] rd_data,
    output logic                       rd_valid,
    output logic [CW-1:0]              count,
    output logic                       full,
    output logic                       drop_err
);

    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic          rd_valid_q;
    logic          wr_en;
    acc_mode_t     mode_e;

    assign mode_e = acc_mode_t'(mode);

    // clear and rewind both swallow a coincident beat without flagging it.
    assign wr_en = in_valid & ~full_q & ~clear & ~rewind;

    always_comb begin
        wr_row_d = wr_row_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (clear) begin
            wr_row_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else if (rewind) begin
            wr_row_d = '0;
            count_d  = '0;
        end else if (in_valid) begin
            if (full_q) begin
                drop_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
                // Pointer parks on the last row rather than wrapping.
                if (wr_row_q != RW'(DEPTH - 1)) begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_row_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            drop_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_row_q   <= wr_row_d;
            count_q    <= count_d;
            full_q     <= full_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_en;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        accumulator_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .RW     (RW)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en),
            .wr_row_i  (wr_row_q),
            .mode_i    (mode_e),
            .wr_data_i (in_data[c*DATA_W +: DATA_W]),
            .clear_i   (clear),
            .rd_en_i   (rd_en),
            .rd_row_i  (rd_row),
            .rd_data_o (rd_data[c*DATA_W +: DATA_W])
        );
    end

    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign full     = full_q;
    assign drop_err = drop_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank (DATA_W=32, CHANNELS=2, DEPTH=4).
// Expected values are hand-computed constants.
module tb_accumulator_bank;

    localparam int DW = 32;
    localparam int CH = 2;
    localparam int DP = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [CH*DW-1:0]  in_data;
    logic              mode;
    logic              rewind;
    logic              clear;
    logic              rd_en;
    logic [1:0]        rd_row;
    logic [CH*DW-1:0]  rd_data;
    logic              rd_valid;
    logic [2:0]        count;
    logic              full;
    logic              drop_err;

    int n_chk;
    int n_err;

    accumulator_bank #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .DEPTH    (DP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .mode     (mode),
        .rewind   (rewind),
        .clear    (clear),
        .rd_en    (rd_en),
        .rd_row   (rd_row),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .drop_err (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic [31:0] a,
                        input logic [31:0] b);
        in_valid = 1'b1;
        mode     = m;
        in_data  = {b, a};
        step();
        in_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] row,
                      input logic [31:0] a, input logic [31:0] b);
        rd_en  = 1'b1;
        rd_row = row;
        step();
        rd_en  = 1'b0;
        check({tag, "_v"}, {63'd0, rd_valid}, 64'd1);
        check(tag, rd_data, {b, a});
    endtask

    task automatic pulse_rewind();
        rewind = 1'b1;
        step();
        rewind = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        mode     = 1'b0;
        rewind   = 1'b0;
        clear    = 1'b0;
        rd_en    = 1'b0;
        rd_row   = '0;
        step();
        step();
        reset = 1'b0;
        step();

        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_drop", {63'd0, drop_err}, 64'd0);
        check("rst_rdv", {63'd0, rd_valid}, 64'd0);
        check("rst_rdd", rd_data, 64'd0);

        // Overwrite fill, zero row included.
        beat(1'b0, 32'd1, 32'd2);
        beat(1'b0, 32'd0, 32'd0);
        beat(1'b0, 32'hFFFF_FFFF, 32'd5);
        check("fill3_full", {63'd0, full}, 64'd0);
        beat(1'b0, 32'd7, 32'd8);
        check("fill4_full", {63'd0, full}, 64'd1);
        check("fill4_cnt", {61'd0, count}, 64'd4);
        rd("ow_r0", 2'd0, 32'd1, 32'd2);
        rd("ow_r1", 2'd1, 32'd0, 32'd0);
        rd("ow_r2", 2'd2, 32'hFFFF_FFFF, 32'd5);
        rd("ow_r3", 2'd3, 32'd7, 32'd8);
        step();
        check("rdv_drop", {63'd0, rd_valid}, 64'd0);
        check("rdd_hold", rd_data, {32'd8, 32'd7});

        // Overflow, rewind keeps flag, clear wipes it.
        beat(1'b0, 32'd9, 32'd9);
        check("ovf_drop", {63'd0, drop_err}, 64'd1);
        rd("ovf_r3", 2'd3, 32'd7, 32'd8);
        pulse_rewind();
        check("rew_cnt", {61'd0, count}, 64'd0);
        check("rew_full", {63'd0, full}, 64'd0);
        check("rew_drop", {63'd0, drop_err}, 64'd1);
        pulse_clear();
        check("clr_drop", {63'd0, drop_err}, 64'd0);
        for (int r = 0; r < DP; r++) begin
            rd("clr_row", 2'(r), 32'd0, 32'd0);
        end

        // Two-pass accumulate.
        for (int r = 0; r < DP; r++) begin
            beat(1'b0, 32'(r + 1), 32'(r + 1));
        end
        pulse_rewind();
        for (int r = 0; r < DP; r++) begin
            beat(1'b1, 32'd10, 32'd20);
        end
        rd("acc_r0", 2'd0, 32'd11, 32'd21);
        rd("acc_r1", 2'd1, 32'd12, 32'd22);
        rd("acc_r2", 2'd2, 32'd13, 32'd23);
        rd("acc_r3", 2'd3, 32'd14, 32'd24);
        check("acc_drop", {63'd0, drop_err}, 64'd0);

        // Wrap modulo 2^32.
        pulse_clear();
        beat(1'b0, 32'hFFFF_FFFF, 32'd5);
        pulse_rewind();
        beat(1'b1, 32'd2, 32'd3);
        rd("wrap_r0", 2'd0, 32'd1, 32'd8);
        check("wrap_drop", {63'd0, drop_err}, 64'd0);

        // Beat coinciding with rewind is swallowed silently.
        in_valid = 1'b1;
        in_data  = {32'd99, 32'd99};
        mode     = 1'b0;
        rewind   = 1'b1;
        step();
        in_valid = 1'b0;
        rewind   = 1'b0;
        check("colrw_cnt", {61'd0, count}, 64'd0);
        check("colrw_drop", {63'd0, drop_err}, 64'd0);
        rd("colrw_r0", 2'd0, 32'd1, 32'd8);

        // Same-edge read/write of row 1 returns old contents.
        beat(1'b0, 32'd5, 32'd6);
        rd_en  = 1'b1;
        rd_row = 2'd1;
        beat(1'b0, 32'd7, 32'd7);
        rd_en  = 1'b0;
        check("colrd_old", rd_data, 64'd0);
        rd("colrd_new", 2'd1, 32'd7, 32'd7);

        // Read during clear returns pre-clear contents.
        rd_en  = 1'b1;
        rd_row = 2'd1;
        pulse_clear();
        rd_en  = 1'b0;
        check("rdclr_old", rd_data, {32'd7, 32'd7});
        rd("rdclr_new", 2'd1, 32'd0, 32'd0);

        // Async reset mid-fill.
        beat(1'b0, 32'd1, 32'd1);
        rd_en  = 1'b1;
        rd_row = 2'd0;
        beat(1'b0, 32'd2, 32'd2);
        rd_en  = 1'b0;
        check("ar_pre_cnt", {61'd0, count}, 64'd2);
        check("ar_pre_rdv", {63'd0, rd_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_cnt", {61'd0, count}, 64'd0);
        check("ar_full", {63'd0, full}, 64'd0);
        check("ar_rdv", {63'd0, rd_valid}, 64'd0);
        check("ar_rdd", rd_data, 64'd0);
        check("ar_drop", {63'd0, drop_err}, 64'd0);
        #1;
        reset = 1'b0;
        step();
        beat(1'b0, 32'd3, 32'd4);
        check("ar_post_cnt", {61'd0, count}, 64'd1);
        rd("ar_post_r0", 2'd0, 32'd3, 32'd4);
        rd("ar_post_r1", 2'd1, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
